// File: rtl/bm_functional_checker_if.sv
// Bus between the functional-test benchmark and its response checker.
// Master drives operands, opcode counter and DUT results; slave returns the verdict.
interface bm_functional_checker_if #(
  parameter int unsigned ERR_W = 16
) ();
  logic             start;
  logic             sample_valid;
  logic [7:0]       a_in;
  logic [7:0]       b_in;
  logic [7:0]       c_in;
  logic [7:0]       d_in;
  logic [7:0]       dut_counter;
  logic [15:0]      dut_out0;
  logic [15:0]      dut_out1;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] error_count;
  logic [7:0]       first_err_index;
  logic [2:0]       first_err_field;

  modport master (
    output start, sample_valid, a_in, b_in, c_in, d_in, dut_counter, dut_out0, dut_out1,
    input  busy, done, pass, error_count, first_err_index, first_err_field
  );

  modport slave (
    input  start, sample_valid, a_in, b_in, c_in, d_in, dut_counter, dut_out0, dut_out1,
    output busy, done, pass, error_count, first_err_index, first_err_field
  );
endinterface

// File: rtl/bm_functional_checker.sv
// Response monitor for the counter-sequenced ALU benchmark: latches each sample, recomputes the
// expected results one cycle later and accumulates an error count and first-failure record.
module bm_functional_checker #(
  parameter int unsigned CHECK_LEN = 256,
  parameter int unsigned ERR_W     = 16
) (
  input logic                    clock,
  input logic                    reset,
  bm_functional_checker_if.slave bus
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StArm   = 3'd1;
  localparam logic [2:0] StCheck = 3'd2;
  localparam logic [2:0] StDrain = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  localparam logic [15:0]      LastSample = 16'(CHECK_LEN - 1);
  localparam logic [ERR_W-1:0] ErrMax     = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ErrOne     = ERR_W'(1);

  logic [2:0]       state_q, state_d;
  logic [15:0]      samples_q, samples_d;
  logic             pending_q, pending_d;
  logic [7:0]       op_q, op_d;
  logic [7:0]       a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [7:0]       first_idx_q, first_idx_d;
  logic [2:0]       first_fld_q, first_fld_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic [15:0] a16, b16, c16, d16, cd_prod;
  logic [15:0] exp_out0, exp_out1;
  logic [7:0]  exp_cnt;
  logic [2:0]  mism;

  // Operands are zero-extended before every operator, including the inversion.
  assign a16     = {8'h00, a_q};
  assign b16     = {8'h00, b_q};
  assign c16     = {8'h00, c_q};
  assign d16     = {8'h00, d_q};
  assign cd_prod = c16 * d16;

  always_comb begin
    exp_out0 = 16'h00CD;
    case (op_q)
      8'd0:    exp_out0 = a16 & b16;
      8'd1:    exp_out0 = a16 | b16;
      8'd2:    exp_out0 = a16 ^ b16;
      8'd3:    exp_out0 = a16 * b16;
      8'd4:    exp_out0 = a16 + b16;
      8'd5:    exp_out0 = a16 - b16;
      8'd6:    exp_out0 = cd_prod;
      8'd7:    exp_out0 = c16 + d16;
      8'd8:    exp_out0 = c16 - d16;
      8'd9:    exp_out0 = ~c16 & d16;
      8'd10:   exp_out0 = (cd_prod != 16'd0) ? (c16 + d16) : (c16 - d16);
      default: exp_out0 = 16'h00CD;
    endcase
    exp_out1 = (op_q <= 8'd15) ? 16'd1 : 16'd0;
    exp_cnt  = op_q + 8'd1;
    mism     = {bus.dut_counter != exp_cnt, bus.dut_out1 != exp_out1, bus.dut_out0 != exp_out0};
  end

  always_comb begin
    state_d     = state_q;
    samples_d   = samples_q;
    pending_d   = 1'b0;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    d_d         = d_q;
    err_cnt_d   = err_cnt_q;
    first_idx_d = first_idx_q;
    first_fld_d = first_fld_q;
    done_d      = 1'b0;
    pass_d      = pass_q;

    // Saturation never returns the count to zero, so zero means no error seen yet.
    if (pending_q && (mism != 3'b000)) begin
      if (err_cnt_q == '0) begin
        first_idx_d = op_q;
        first_fld_d = mism;
      end
      if (err_cnt_q != ErrMax) err_cnt_d = err_cnt_q + ErrOne;
    end

    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d     = StArm;
          samples_d   = '0;
          err_cnt_d   = '0;
          first_idx_d = '0;
          first_fld_d = '0;
          pass_d      = 1'b0;
        end
      end
      StArm: state_d = StCheck;
      StCheck: begin
        if (bus.sample_valid) begin
          op_d      = bus.dut_counter;
          a_d       = bus.a_in;
          b_d       = bus.b_in;
          c_d       = bus.c_in;
          d_d       = bus.d_in;
          pending_d = 1'b1;
          samples_d = samples_q + 16'd1;
          if (samples_q == LastSample) state_d = StDrain;
        end
      end
      StDrain: begin
        state_d = StDone;
        done_d  = 1'b1;
        // The final compare lands this cycle, so judge on the updated count.
        pass_d  = (err_cnt_d == '0);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      samples_q   <= '0;
      pending_q   <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      err_cnt_q   <= '0;
      first_idx_q <= '0;
      first_fld_q <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      samples_q   <= samples_d;
      pending_q   <= pending_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      d_q         <= d_d;
      err_cnt_q   <= err_cnt_d;
      first_idx_q <= first_idx_d;
      first_fld_q <= first_fld_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign bus.busy            = (state_q == StArm) || (state_q == StCheck) || (state_q == StDrain);
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.error_count     = err_cnt_q;
  assign bus.first_err_index = first_idx_q;
  assign bus.first_err_field = first_fld_q;

endmodule

// File: tb/tb_bm_functional_checker.sv
// Bench for bm_functional_checker: a golden benchmark DUT with fault knobs feeds two checker
// instances; a behavioural model of the checker is compared against both on every cycle.
module tb_bm_functional_checker;

  localparam int PIdle  = 0;
  localparam int PArm   = 1;
  localparam int PCheck = 2;
  localparam int PDrain = 3;
  localparam int PDone  = 4;

  typedef struct {
    int         phase;
    bit         pend;
    logic [7:0] op, a, b, c, d;
    int         samples;
    int         errs;
    logic [7:0] fidx;
    logic [2:0] ffld;
    bit         done;
    bit         pass;
  } mdl_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_a, start_b, g_valid, g_run, g_load, g_skip, g_bad_all;
  logic [7:0]  g_load_val, ga, gb, gc, gd, g_cnt;
  logic [15:0] g_out0, g_out1;
  int          g_f0_op, g_f1_op;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;
  int e_first, e_last, e_done;

  mdl_t ma, mb;

  bm_functional_checker_if #(.ERR_W(16)) if_a ();
  bm_functional_checker_if #(.ERR_W(2))  if_b ();

  assign if_a.start        = start_a;
  assign if_a.sample_valid = g_valid;
  assign if_a.a_in         = ga;
  assign if_a.b_in         = gb;
  assign if_a.c_in         = gc;
  assign if_a.d_in         = gd;
  assign if_a.dut_counter  = g_cnt;
  assign if_a.dut_out0     = g_out0;
  assign if_a.dut_out1     = g_out1;
  assign if_b.start        = start_b;
  assign if_b.sample_valid = g_valid;
  assign if_b.a_in         = ga;
  assign if_b.b_in         = gb;
  assign if_b.c_in         = gc;
  assign if_b.d_in         = gd;
  assign if_b.dut_counter  = g_cnt;
  assign if_b.dut_out0     = g_out0;
  assign if_b.dut_out1     = g_out1;

  bm_functional_checker #(.CHECK_LEN(256), .ERR_W(16)) dut_a (
    .clock (clk),
    .reset (rst),
    .bus   (if_a)
  );

  bm_functional_checker #(.CHECK_LEN(12), .ERR_W(2)) dut_b (
    .clock (clk),
    .reset (rst),
    .bus   (if_b)
  );

  // Benchmark ALU in plain integer arithmetic, truncated to 16 bits at the end.
  function automatic logic [15:0] alu_ref(input logic [7:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [7:0] c,
                                          input logic [7:0] d);
    int ia, ib, ic, id, r;
    ia = 32'(a);
    ib = 32'(b);
    ic = 32'(c);
    id = 32'(d);
    case (op)
      8'd0:    r = ia & ib;
      8'd1:    r = ia | ib;
      8'd2:    r = ia ^ ib;
      8'd3:    r = ia * ib;
      8'd4:    r = ia + ib;
      8'd5:    r = ia - ib;
      8'd6:    r = ic * id;
      8'd7:    r = ic + id;
      8'd8:    r = ic - id;
      8'd9:    r = (~ic) & id;
      8'd10:   r = (ic * id != 0) ? ic + id : ic - id;
      default: r = 32'hCD;
    endcase
    return 16'(r);
  endfunction

  // Golden benchmark DUT with fault injection.
  always @(posedge clk) begin
    if (g_load) begin
      g_cnt <= g_load_val;
    end else if (g_run) begin
      if (g_bad_all)                  g_out0 <= 16'hBEEF;
      else if (32'(g_cnt) == g_f0_op) g_out0 <= 16'h0000;
      else                            g_out0 <= alu_ref(g_cnt, ga, gb, gc, gd);
      if (32'(g_cnt) == g_f1_op)      g_out1 <= 16'd0;
      else                            g_out1 <= (g_cnt < 8'd16) ? 16'd1 : 16'd0;
      g_cnt <= (g_skip && g_cnt == 8'd9) ? 8'd11 : g_cnt + 8'd1;
    end
  end

  function automatic mdl_t mdl_step(input mdl_t m, input bit rst_v, input bit st, input int len);
    mdl_t       n;
    logic [2:0] mask;
    n = m;
    if (rst_v) begin
      n = '{default: 0};
      return n;
    end
    n.done = 1'b0;
    n.pend = 1'b0;
    if (m.pend) begin
      mask[0] = (g_out0 != alu_ref(m.op, m.a, m.b, m.c, m.d));
      mask[1] = (g_out1 != ((m.op < 8'd16) ? 16'd1 : 16'd0));
      mask[2] = (g_cnt != 8'(m.op + 1));
      if (mask != 3'b000) begin
        if (m.errs == 0) begin
          n.fidx = m.op;
          n.ffld = mask;
        end
        n.errs = m.errs + 1;
      end
    end
    case (m.phase)
      PIdle, PDone: if (st) begin
        n.phase   = PArm;
        n.errs    = 0;
        n.fidx    = 8'd0;
        n.ffld    = 3'd0;
        n.pass    = 1'b0;
        n.samples = 0;
      end
      PArm: n.phase = PCheck;
      PCheck: if (g_valid) begin
        n.op      = g_cnt;
        n.a       = ga;
        n.b       = gb;
        n.c       = gc;
        n.d       = gd;
        n.pend    = 1'b1;
        n.samples = m.samples + 1;
        if (n.samples == len) n.phase = PDrain;
      end
      PDrain: begin
        n.phase = PDone;
        n.done  = 1'b1;
        n.pass  = (n.errs == 0);
      end
      default: ;
    endcase
    return n;
  endfunction

  always @(posedge clk) begin
    ma <= mdl_step(ma, rst, start_a, 256);
    mb <= mdl_step(mb, rst, start_b, 12);
  end

  function automatic int sat_cnt(input int e, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (e > mx) ? mx : e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic compare_all();
    chk("a_busy", 32'(if_a.busy), 32'(ma.phase == PArm || ma.phase == PCheck ||
                                       ma.phase == PDrain));
    chk("a_done", 32'(if_a.done), 32'(ma.done));
    chk("a_pass", 32'(if_a.pass), 32'(ma.pass));
    chk("a_errs", 32'(if_a.error_count), 32'(sat_cnt(ma.errs, 16)));
    chk("a_fidx", 32'(if_a.first_err_index), 32'(ma.fidx));
    chk("a_ffld", 32'(if_a.first_err_field), 32'(ma.ffld));
    chk("b_busy", 32'(if_b.busy), 32'(mb.phase == PArm || mb.phase == PCheck ||
                                       mb.phase == PDrain));
    chk("b_done", 32'(if_b.done), 32'(mb.done));
    chk("b_pass", 32'(if_b.pass), 32'(mb.pass));
    chk("b_errs", 32'(if_b.error_count), 32'(sat_cnt(mb.errs, 2)));
    chk("b_fidx", 32'(if_b.first_err_index), 32'(mb.fidx));
    chk("b_ffld", 32'(if_b.first_err_field), 32'(mb.ffld));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    edge_n++;
    compare_all();
  endtask

  // One run: start (with counter preload), ARM cycle with a stray sample_valid, n samples
  // with an optional gap, a start pulse while busy, then a bounded wait for done.
  task automatic run(input bit sel_b, input logic [7:0] cnt0, input int n, input int gap_at,
                     input int gap_len, input int bad_n);
    if (sel_b) start_b = 1'b1;
    else       start_a = 1'b1;
    g_load     = 1'b1;
    g_load_val = cnt0;
    g_valid    = 1'b0;
    g_run      = 1'b0;
    step();
    chk("start_clears_pass", 32'(sel_b ? if_b.pass : if_a.pass), 32'd0);
    chk("start_clears_errs", sel_b ? 32'(if_b.error_count) : 32'(if_a.error_count), 32'd0);
    start_a = 1'b0;
    start_b = 1'b0;
    g_load  = 1'b0;
    g_valid = 1'b1;
    step();
    e_first = -1;
    e_last  = -1;
    e_done  = -1;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        g_valid   = 1'b0;
        g_run     = 1'b1;
        g_bad_all = 1'b0;
        repeat (gap_len) step();
      end
      g_valid   = 1'b1;
      g_run     = 1'b1;
      g_bad_all = (i < bad_n);
      if (i == 3) begin
        if (sel_b) start_b = 1'b1;
        else       start_a = 1'b1;
      end
      step();
      start_a = 1'b0;
      start_b = 1'b0;
      if (i == 0) e_first = edge_n;
      e_last = edge_n;
    end
    g_valid   = 1'b0;
    g_run     = 1'b0;
    g_bad_all = 1'b0;
    for (int k = 0; k < 6 && e_done < 0; k++) begin
      step();
      if ((sel_b ? if_b.done : if_a.done) === 1'b1) e_done = edge_n;
    end
    chk("done_seen", 32'(e_done >= 0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    start_a    = 1'b0;
    start_b    = 1'b0;
    g_valid    = 1'b0;
    g_run      = 1'b0;
    g_load     = 1'b0;
    g_load_val = 8'd0;
    g_skip     = 1'b0;
    g_bad_all  = 1'b0;
    g_f0_op    = -1;
    g_f1_op    = -1;
    ga         = 8'h0F;
    gb         = 8'h3C;
    gc         = 8'd3;
    gd         = 8'd5;

    // Pin the reference ALU to hand-computed results.
    chk("ref_op3", 32'(alu_ref(8'd3, ga, gb, gc, gd)), 32'h0384);
    chk("ref_op4", 32'(alu_ref(8'd4, ga, gb, gc, gd)), 32'h004B);
    chk("ref_op5", 32'(alu_ref(8'd5, ga, gb, gc, gd)), 32'hFFD3);
    chk("ref_op8", 32'(alu_ref(8'd8, ga, gb, gc, gd)), 32'hFFFE);
    chk("ref_op9", 32'(alu_ref(8'd9, ga, gb, gc, gd)), 32'h0004);
    chk("ref_op10", 32'(alu_ref(8'd10, ga, gb, gc, gd)), 32'h0008);
    chk("ref_op11", 32'(alu_ref(8'd11, ga, gb, gc, gd)), 32'h00CD);

    step();
    step();
    rst = 1'b0;
    chk("rst_busy", 32'(if_a.busy), 32'd0);
    chk("rst_errs", 32'(if_a.error_count), 32'd0);
    chk("rst_pass", 32'(if_b.pass), 32'd0);

    // Clean sweep of all 256 opcodes.
    run(1'b0, 8'd0, 256, -1, 0, 0);
    chk("sweep_done_cycle", 32'(e_done - e_first + 2), 32'd258);
    chk("sweep_pass", 32'(if_a.pass), 32'd1);
    chk("sweep_errs", 32'(if_a.error_count), 32'd0);

    // Injected result faults on op4 (out0) and op7 (out1).
    g_f0_op = 4;
    g_f1_op = 7;
    run(1'b0, 8'd0, 256, -1, 0, 0);
    g_f0_op = -1;
    g_f1_op = -1;
    chk("fault_errs", 32'(if_a.error_count), 32'd2);
    chk("fault_fidx", 32'(if_a.first_err_index), 32'd4);
    chk("fault_ffld", 32'(if_a.first_err_field), 32'b001);
    chk("fault_pass", 32'(if_a.pass), 32'd0);

    // Counter skips 9 -> 11.
    g_skip = 1'b1;
    run(1'b0, 8'd0, 256, -1, 0, 0);
    g_skip = 1'b0;
    chk("skip_fidx", 32'(if_a.first_err_index), 32'd9);
    chk("skip_ffld", 32'(if_a.first_err_field), 32'b100);
    chk("skip_errs", 32'(if_a.error_count), 32'd1);

    // Wrap through 255 -> 0 with a three-cycle gap.
    run(1'b1, 8'd250, 12, 2, 3, 0);
    chk("wrap_pass", 32'(if_b.pass), 32'd1);
    chk("wrap_errs", 32'(if_b.error_count), 32'd0);
    chk("wrap_done_cycle", 32'(e_done - e_first + 2), 32'd17);
    chk("wrap_done_after_last", 32'(e_done - e_last), 32'd1);

    // Saturation with a 2-bit counter, started from DONE.
    run(1'b1, 8'd40, 12, -1, 0, 10);
    chk("sat_errs", 32'(if_b.error_count), 32'd3);
    chk("sat_fidx", 32'(if_b.first_err_index), 32'd40);
    chk("sat_ffld", 32'(if_b.first_err_field), 32'b001);
    chk("sat_pass", 32'(if_b.pass), 32'd0);
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("restart_errs", 32'(if_b.error_count), 32'd0);
    chk("restart_busy", 32'(if_b.busy), 32'd1);

    // Reset one cycle after latching op 20, whose result is corrupted.
    g_f0_op    = 20;
    start_a    = 1'b1;
    g_load     = 1'b1;
    g_load_val = 8'd0;
    step();
    start_a = 1'b0;
    g_load  = 1'b0;
    g_valid = 1'b1;
    step();
    for (int i = 0; i <= 20; i++) begin
      g_valid = 1'b1;
      g_run   = 1'b1;
      step();
    end
    g_valid = 1'b0;
    g_run   = 1'b0;
    rst     = 1'b1;
    step();
    rst     = 1'b0;
    g_f0_op = -1;
    chk("mrst_busy", 32'(if_a.busy), 32'd0);
    chk("mrst_errs", 32'(if_a.error_count), 32'd0);
    chk("mrst_fidx", 32'(if_a.first_err_index), 32'd0);
    chk("mrst_ffld", 32'(if_a.first_err_field), 32'd0);
    step();
    chk("mrst_no_stale", 32'(if_a.error_count), 32'd0);
    run(1'b1, 8'd100, 12, -1, 0, 0);
    chk("post_rst_pass", 32'(if_b.pass), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
